v_upd_ingress: RTL and testbench

V_UPD_INGRESS -- requirements
Module: v_upd_ingress

---
 rtl/v_pkg.sv | 37 +++
 rtl/v_upd_fifo.sv | 60 ++++++
 rtl/v_upd_ingress.sv | 114 +++++++++++
 tb/tb_v_upd_ingress.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/v_pkg.sv
`default_nettype none
// ============================================================================
// Module      : v_pkg
// Description : Shared types and constants for the v table and its update
//               ingress queue (payload fields, packed update record, sizes).
// Revision    : 1.0 - initial release
// ============================================================================
package v_pkg;

  localparam int ID_W   = 4;
  localparam int KEY_W  = 16;
  localparam int SIZE_W = 8;

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [KEY_W-1:0]  key_t;
  typedef logic [SIZE_W-1:0] size_t;

  typedef enum logic [1:0] {
    CMD_ADD = 2'd0,
    CMD_SUB = 2'd1,
    CMD_SET = 2'd2,
    CMD_CLR = 2'd3
  } cmd_t;

  // Update queue depth and the number of v update-pipe stages (s1..s4)
  localparam int UPD_Q_N    = 4;
  localparam int V_HAZARD_N = 4;

  typedef struct packed {
    id_t   prod_id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } upd_t;

endpackage
`default_nettype wire

// File: rtl/v_upd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : v_upd_fifo
// Description : Flop-based in-order FIFO holding pending v updates. The caller
//               guarantees no push when full and no pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module v_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   occ_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Occupancy next-state: a simultaneous push and pop cancel out
  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2**PTR_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
    end
  end

  assign dout_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule
`default_nettype wire

// File: rtl/v_upd_ingress.sv
`default_nettype none
// ============================================================================
// Module      : v_upd_ingress
// Description : Update queue in front of v. Issues the queue head in order,
//               holding it while v is initialising or while an update with
//               the same prod_id is still inside the v update pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module v_upd_ingress
  import v_pkg::*;
#(
  parameter int DEPTH    = UPD_Q_N,
  parameter int HAZARD_N = V_HAZARD_N
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_in_vld,
  output logic                      o_in_rdy,
  input  id_t                       i_in_prod_id,
  input  cmd_t                      i_in_cmd,
  input  key_t                      i_in_key,
  input  size_t                     i_in_size,
  input  logic                      i_busy,
  output logic                      o_upd_vld_r,
  output id_t                       o_upd_prod_id_r,
  output cmd_t                      o_upd_cmd_r,
  output key_t                      o_upd_key_r,
  output size_t                     o_upd_size_r,
  output logic [$clog2(DEPTH):0]    o_occ_r,
  output logic                      o_hzd_stall_r
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  upd_t             in_upd, head;
  logic [OCC_W-1:0] occ;
  logic             push, nonempty, hazard;
  logic             upd_vld_d, hzd_stall_d;

  // Issue history: one slot per v pipe stage, slot 0 is the newest issue
  logic [HAZARD_N-1:0] hist_vld_q;
  id_t                 hist_id_q [HAZARD_N];

  upd_t upd_q;
  logic upd_vld_q, hzd_stall_q;

  assign in_upd = '{prod_id: i_in_prod_id, cmd: i_in_cmd, key: i_in_key, size: i_in_size};

  // Ready comes purely from registered occupancy, so a pop never frees a full slot early
  assign o_in_rdy = (occ != OCC_W'(DEPTH));
  assign push     = i_in_vld & o_in_rdy;
  assign nonempty = (occ != '0);

  v_upd_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(upd_t))
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  (in_upd),
    .pop_i  (upd_vld_d),
    .dout_o (head),
    .occ_o  (occ)
  );

  // Hazard detect and issue decision for the queue head
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < HAZARD_N; k++) begin
      if (hist_vld_q[k] && (hist_id_q[k] == head.prod_id)) hazard = 1'b1;
    end
    upd_vld_d   = nonempty & ~i_busy & ~hazard;
    hzd_stall_d = nonempty & hazard;
  end

  // History shifts every cycle; slot 0 records this cycle's issue (if any)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_vld_q <= '0;
      for (int k = 0; k < HAZARD_N; k++) hist_id_q[k] <= '0;
    end else begin
      for (int k = HAZARD_N - 1; k > 0; k--) begin
        hist_vld_q[k] <= hist_vld_q[k-1];
        hist_id_q[k]  <= hist_id_q[k-1];
      end
      hist_vld_q[0] <= upd_vld_d;
      hist_id_q[0]  <= head.prod_id;
    end
  end

  // Registered strobe/payload towards v; payload holds between issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_vld_q   <= 1'b0;
      upd_q       <= '0;
      hzd_stall_q <= 1'b0;
    end else begin
      upd_vld_q   <= upd_vld_d;
      hzd_stall_q <= hzd_stall_d;
      if (upd_vld_d) upd_q <= head;
    end
  end

  assign o_upd_vld_r     = upd_vld_q;
  assign o_upd_prod_id_r = upd_q.prod_id;
  assign o_upd_cmd_r     = upd_q.cmd;
  assign o_upd_key_r     = upd_q.key;
  assign o_upd_size_r    = upd_q.size;
  assign o_occ_r         = occ;
  assign o_hzd_stall_r   = hzd_stall_q;

endmodule
`default_nettype wire

// File: tb/tb_v_upd_ingress.sv
`default_nettype none
// ============================================================================
// Module      : tb_v_upd_ingress
// Description : Directed self-checking bench for v_upd_ingress with a payload
//               scoreboard and per-cycle strobe/stall/accept recording.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_v_upd_ingress;
  import v_pkg::*;

  localparam int DEPTH    = 4;
  localparam int HAZARD_N = 4;
  localparam int OCC_W    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_in_vld;
  logic             o_in_rdy;
  id_t              i_in_prod_id;
  cmd_t             i_in_cmd;
  key_t             i_in_key;
  size_t            i_in_size;
  logic             i_busy;
  logic             o_upd_vld_r;
  id_t              o_upd_prod_id_r;
  cmd_t             o_upd_cmd_r;
  key_t             o_upd_key_r;
  size_t            o_upd_size_r;
  logic [OCC_W-1:0] o_occ_r;
  logic             o_hzd_stall_r;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          idx;
  logic        last_acc;
  logic [31:0] vld_vec, stall_vec, acc_vec;
  upd_t        sb[$];

  v_upd_ingress #(.DEPTH(DEPTH), .HAZARD_N(HAZARD_N)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_in_vld        (i_in_vld),
    .o_in_rdy        (o_in_rdy),
    .i_in_prod_id    (i_in_prod_id),
    .i_in_cmd        (i_in_cmd),
    .i_in_key        (i_in_key),
    .i_in_size       (i_in_size),
    .i_busy          (i_busy),
    .o_upd_vld_r     (o_upd_vld_r),
    .o_upd_prod_id_r (o_upd_prod_id_r),
    .o_upd_cmd_r     (o_upd_cmd_r),
    .o_upd_key_r     (o_upd_key_r),
    .o_upd_size_r    (o_upd_size_r),
    .o_occ_r         (o_occ_r),
    .o_hzd_stall_r   (o_hzd_stall_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input int id, input int key, input int size);
    i_in_vld     = vld;
    i_in_prod_id = id_t'(id);
    i_in_cmd     = cmd_t'(id[1:0]);
    i_in_key     = key_t'(key);
    i_in_size    = size_t'(size);
  endtask

  // One clock: record acceptance, advance, sample outputs, score any issue
  task automatic tick();
    upd_t got, exp;
    last_acc = i_in_vld && o_in_rdy;
    if (last_acc) sb.push_back('{prod_id: i_in_prod_id, cmd: i_in_cmd, key: i_in_key, size: i_in_size});
    acc_vec[cyc] = last_acc;
    @(posedge clk);
    #1;
    cyc++;
    vld_vec[cyc]   = o_upd_vld_r;
    stall_vec[cyc] = o_hzd_stall_r;
    if (o_upd_vld_r) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow: observed issue at cycle %0d, expected none", cyc);
      end else begin
        got = '{prod_id: o_upd_prod_id_r, cmd: o_upd_cmd_r, key: o_upd_key_r, size: o_upd_size_r};
        exp = sb.pop_front();
        check("payload", 32'(got), 32'(exp));
      end
    end
  endtask

  task automatic check_regs_zero(input string tag);
    check({tag, "_vld"},   o_upd_vld_r, 0);
    check({tag, "_occ"},   o_occ_r, 0);
    check({tag, "_stall"}, o_hzd_stall_r, 0);
    check({tag, "_pay"},   32'({o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r}), 0);
  endtask

  // Hold reset for two edges, release mid-cycle; cycle 0 starts at release
  task automatic do_reset();
    rst    = 1'b1;
    i_busy = 1'b0;
    drive(1'b0, 0, 0, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_regs_zero("rst");
    rst       = 1'b0;
    sb.delete();
    cyc       = 0;
    vld_vec   = '0;
    stall_vec = '0;
    acc_vec   = '0;
    check("rdy_after_rst", o_in_rdy, 1);
  endtask

  initial begin
    i_busy = 1'b0;
    drive(1'b0, 0, 0, 0);
    do_reset();

    // Single update: occ 1 at t=1, strobe at t=2 with payload, occ back to 0
    drive(1'b1, 3, 'h10, 5);
    tick();
    check("single_occ_t1", o_occ_r, 1);
    check("single_vld_t1", o_upd_vld_r, 0);
    drive(1'b0, 0, 0, 0);
    tick();
    check("single_vld_t2", o_upd_vld_r, 1);
    check("single_occ_t2", o_occ_r, 0);
    tick();
    check("single_one_shot", o_upd_vld_r, 0);

    // Same id back-to-back: issues at t=2 and t=7, stall t=3..6
    do_reset();
    drive(1'b1, 1, 'h20, 1);
    tick();
    drive(1'b1, 1, 'h21, 2);
    tick();
    drive(1'b0, 0, 0, 0);
    repeat (8) tick();
    check("same_id_vld_cycles", vld_vec & 32'h7FF, 32'h084);
    check("same_id_stall_cycles", stall_vec & 32'h7FF, 32'h078);
    check("same_id_sb_empty", sb.size(), 0);

    // Ids 1,2,1: issues at t=2,3,7 in order; stall t=4..6
    do_reset();
    drive(1'b1, 1, 'h30, 1);
    tick();
    drive(1'b1, 2, 'h31, 2);
    tick();
    drive(1'b1, 1, 'h32, 3);
    tick();
    drive(1'b0, 0, 0, 0);
    repeat (7) tick();
    check("mixed_vld_cycles", vld_vec & 32'h7FF, 32'h08C);
    check("mixed_stall_cycles", stall_vec & 32'h7FF, 32'h070);
    check("mixed_sb_empty", sb.size(), 0);

    // Busy holds issue; queue fills; busy drops at t=10; full+pop blocks push
    do_reset();
    idx = 0;
    repeat (17) begin
      i_busy = (cyc < 10);
      if (idx < 5) drive(1'b1, idx + 1, 'h40 + idx, idx + 1);
      else         drive(1'b0, 0, 0, 0);
      tick();
      if (last_acc) idx++;
      if (cyc == 4) begin
        check("busy_full_occ", o_occ_r, 4);
        check("busy_full_rdy", o_in_rdy, 0);
      end
    end
    check("busy_accept_cycles", acc_vec & 32'h1FFFF, 32'h0080F);
    check("full_pop_no_push", acc_vec[10], 0);
    check("full_pop_next_push", acc_vec[11], 1);
    check("busy_vld_cycles", vld_vec & 32'h3FFFF, 32'h0F800);
    check("busy_sb_empty", sb.size(), 0);

    // Reset asserted mid-queue during a hazard stall
    do_reset();
    drive(1'b1, 1, 'h50, 1);
    tick();
    drive(1'b1, 1, 'h51, 2);
    tick();
    drive(1'b1, 2, 'h52, 3);
    tick();
    drive(1'b1, 3, 'h53, 4);
    tick();
    drive(1'b0, 0, 0, 0);
    check("pre_rst_occ", o_occ_r, 3);
    check("pre_rst_stall", o_hzd_stall_r, 1);
    #2;
    rst = 1'b1;
    #1;
    check_regs_zero("async_rst");
    do_reset();
    drive(1'b1, 1, 'h55, 7);
    tick();
    drive(1'b0, 0, 0, 0);
    repeat (6) tick();
    check("post_rst_vld_cycles", vld_vec & 32'hFF, 32'h04);
    check("post_rst_stall_cycles", stall_vec & 32'hFF, 32'h00);
    check("post_rst_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
